// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per
// clock, LSB first, through a single full-subtractor slice with a registered
// borrow. The operation is started with start/busy/done, and the result stays
// held until the next operation completes.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; sampled only in IDLE
//   a      minuend, captured on the accepting edge
//   b      subtrahend, captured on the accepting edge
//   busy   high while the operation is running
//   done   one-cycle pulse; diff/bout/zero were just updated
//   diff   result (a - b) mod 2^WIDTH
//   bout   final borrow; 1 when a < b
//   zero   1 when diff == 0
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-subtractor slice on the current LSBs.
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] sd_next;

    always_comb begin
        d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        // Difference bits enter at the MSB; after WIDTH shifts bit 0 is at LSB.
        sd_next = {d_bit, sd_q[WIDTH-1:1]};
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    sd_d    = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                sd_d = sd_next;
                br_d = br_next;
                if (cnt_q == LAST_CNT) begin
                    // Last bit: publish the completed result, leave the counter
                    // at WIDTH-1 so it never wraps.
                    diff_d  = sd_next;
                    bout_d  = br_next;
                    zero_d  = (sd_next == '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule
